// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner with per-digit blink and decimal points.
// Optional build macro LZ_BLANK_EN blanks digit 5 when it holds 0 (leading-zero suppression).
module seg_scan #(
    parameter int unsigned SCAN_DIV  = 25000,
    parameter int unsigned BLINK_DIV = 80
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] q0,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    input  logic [3:0] q3,
    input  logic [3:0] q4,
    input  logic [3:0] q5,
    input  logic [2:0] blink_sel,
    input  logic [5:0] dp_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_en,
    output logic       scan_tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned FW = $clog2(BLINK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [FW-1:0] r_frame;
    logic          r_phase;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [5:0]    r_dig_en;
    logic          r_tick;

    logic [3:0] w_digit;
    logic       w_dp_req;
    logic [6:0] w_seg_dec;
    logic       w_blank;
    logic       w_slot_start;
    logic       w_slot_end;

    assign w_slot_start = (r_cnt == '0);
    assign w_slot_end   = (r_cnt == CNT_LAST);
    assign w_blank      = r_phase && (r_idx == blink_sel);

    always_comb begin
        w_digit  = 4'd0;
        w_dp_req = 1'b0;
        case (r_idx)
            3'd0: begin w_digit = q0; w_dp_req = dp_mask[0]; end
            3'd1: begin w_digit = q1; w_dp_req = dp_mask[1]; end
            3'd2: begin w_digit = q2; w_dp_req = dp_mask[2]; end
            3'd3: begin w_digit = q3; w_dp_req = dp_mask[3]; end
            3'd4: begin w_digit = q4; w_dp_req = dp_mask[4]; end
            3'd5: begin w_digit = q5; w_dp_req = dp_mask[5]; end
            default: ;
        endcase
    end

    // Active-low segments {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
    always_comb begin
        case (w_digit)
            4'd0:    w_seg_dec = 7'h40;
            4'd1:    w_seg_dec = 7'h79;
            4'd2:    w_seg_dec = 7'h24;
            4'd3:    w_seg_dec = 7'h30;
            4'd4:    w_seg_dec = 7'h19;
            4'd5:    w_seg_dec = 7'h12;
            4'd6:    w_seg_dec = 7'h02;
            4'd7:    w_seg_dec = 7'h78;
            4'd8:    w_seg_dec = 7'h00;
            4'd9:    w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h7F;
        endcase
`ifdef LZ_BLANK_EN
        if (r_idx == 3'd5 && w_digit == 4'd0) begin
            w_seg_dec = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_frame  <= '0;
            r_phase  <= 1'b0;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_dig_en <= 6'h3F;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_slot_end) begin
                // Inter-slot gap: all digits off while idx moves on.
                r_cnt    <= '0;
                r_dig_en <= 6'h3F;
                r_tick   <= 1'b1;
                if (r_idx == 3'd5) begin
                    r_idx <= 3'd0;
                    if (r_frame == FRAME_LAST) begin
                        r_frame <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_frame <= r_frame + FW'(1);
                    end
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_slot_start) begin
                r_seg    <= w_blank ? 7'h7F : w_seg_dec;
                r_dp     <= w_blank ? 1'b1 : ~w_dp_req;
                r_dig_en <= ~(6'd1 << r_idx);
            end
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign dig_en    = r_dig_en;
    assign scan_tick = r_tick;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (SCAN_DIV=4, BLINK_DIV=2): directed literal checks plus
// randomized inputs against a slot/frame arithmetic model compared every cycle.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BD = 2;

    localparam logic [6:0] LIT_SEG [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [5:0] LIT_EN  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    logic       clk_in;
    logic       rst;
    logic [3:0] qa [6];
    logic [2:0] blink_sel;
    logic [5:0] dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_en;
    logic       scan_tick;

    int total = 0;
    int bad   = 0;
    int e     = 0;

    seg_scan #(
        .SCAN_DIV (SD),
        .BLINK_DIV(BD)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .q0       (qa[0]),
        .q1       (qa[1]),
        .q2       (qa[2]),
        .q3       (qa[3]),
        .q4       (qa[4]),
        .q5       (qa[5]),
        .blink_sel(blink_sel),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .dp       (dp),
        .dig_en   (dig_en),
        .scan_tick(scan_tick)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference model: position in the scan follows from the edge count since reset release.
    initial begin
        int         n;
        int         s;
        int         d;
        int         ph;
        int         v;
        bit         have;
        logic [6:0] m_seg;
        logic       m_dp;
        logic [5:0] m_en;
        logic       m_tick;
        have = 0;
        n = -1;
        forever begin
            @(posedge clk_in);
            if (!rst) begin
                have   = 1;
                n      = -1;
                m_seg  = 7'h7F;
                m_dp   = 1'b1;
                m_en   = 6'h3F;
                m_tick = 1'b0;
            end else if (have) begin
                n++;
                s  = n / SD;
                d  = s % 6;
                ph = ((s / 6) / BD) % 2;
                if (n % SD == 0) begin
                    v = int'(qa[d]);
                    if (ph == 1 && int'(blink_sel) == d) begin
                        m_seg = 7'h7F;
                        m_dp  = 1'b1;
                    end else begin
                        m_seg = dec(v);
`ifdef LZ_BLANK_EN
                        if (d == 5 && v == 0) m_seg = 7'h7F;
`endif
                        m_dp = ~dp_mask[d];
                    end
                end
                m_tick = (n % SD == SD - 1);
                m_en   = m_tick ? 6'h3F : ~(6'd1 << d);
            end
            @(negedge clk_in);
            if (have) begin
                chk("model_seg", 32'(seg), 32'(m_seg));
                chk("model_dp", 32'(dp), 32'(m_dp));
                chk("model_dig_en", 32'(dig_en), 32'(m_en));
                chk("model_scan_tick", 32'(scan_tick), 32'(m_tick));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
        e++;
    endtask

    // Advance until edge number k (counted from reset release) has just happened.
    task automatic go(input int k);
        while (e < k + 1) step();
    endtask

    initial begin
        rst       = 1'b0;
        blink_sel = 3'd7;
        dp_mask   = 6'd0;
        for (int i = 0; i < 6; i++) qa[i] = 4'd0;
        step();
        step();
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_dig_en", 32'(dig_en), 32'h3F);
        chk("reset_tick", 32'(scan_tick), 32'h0);

        for (int i = 0; i < 6; i++) qa[i] = 4'(i + 1);
        rst = 1'b1;
        e   = 0;
        for (int n = 0; n < 24; n++) begin
            step();
            chk("scan_seg", 32'(seg), 32'(LIT_SEG[n / 4]));
            if (n % 4 == 3) begin
                chk("gap_dig_en", 32'(dig_en), 32'h3F);
                chk("gap_tick", 32'(scan_tick), 32'h1);
            end else begin
                chk("lit_dig_en", 32'(dig_en), 32'(LIT_EN[n / 4]));
                chk("lit_tick", 32'(scan_tick), 32'h0);
            end
        end

        qa[2]   = 4'hA;
        dp_mask = 6'b000100;
        go(28);
        chk("slot1_dp", 32'(dp), 32'h1);
        go(32);
        chk("slot2_blank_seg", 32'(seg), 32'h7F);
        chk("slot2_dp", 32'(dp), 32'h0);

        go(47);
        blink_sel = 3'd3;
        qa[3]     = 4'd8;
        go(60);
        chk("blink_frame2", 32'(seg), 32'h7F);
        go(84);
        chk("blink_frame3", 32'(seg), 32'h7F);
        go(108);
        chk("blink_frame4", 32'(seg), 32'h00);
        chk("blink_frame4_en", 32'(dig_en), 32'h37);

        go(110);
        qa[5] = 4'd0;
        go(116);
`ifdef LZ_BLANK_EN
        chk("q5_zero", 32'(seg), 32'h7F);
`else
        chk("q5_zero", 32'(seg), 32'h40);
`endif
        qa[5] = 4'd1;
        go(140);
        chk("q5_one", 32'(seg), 32'h79);

        go(157);
        rst = 1'b0;
        step();
        chk("midslot_rst_seg", 32'(seg), 32'h7F);
        chk("midslot_rst_en", 32'(dig_en), 32'h3F);
        chk("midslot_rst_dp", 32'(dp), 32'h1);
        rst = 1'b1;
        e   = 0;
        step();
        chk("post_rst_en", 32'(dig_en), 32'h3E);
        chk("post_rst_seg", 32'(seg), 32'h79);

        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) qa[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) qa[5] = 4'd0;
            if ($urandom_range(0, 7) == 0) dp_mask = 6'($urandom);
            if ($urandom_range(0, 19) == 0) blink_sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
